exec_pipe_unit: RTL

//  Parametrised integer execution pipeline for RV32I R-type (OP) and I-type ALU (OP-IMM) uops.
//  - Replaces the fixed 2-stage execute block.
//  - Adds a valid/ready handshake with backpressure, a configurable depth, flush and an illegal-op flag.
//  - Adds shift/compare ops, a destination-tag pass-through and a saturating retire counter.
//  - Sits between decode/register-read and writeback.

---
 rtl/exec_pipe_unit_pkg.sv | 35 +++
 rtl/exec_pipe_unit_alu_core.sv | 41 ++++
 rtl/exec_pipe_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/exec_pipe_unit_pkg.sv
// Shared encodings for the integer execute pipeline: ALU op codes, RV32I opcodes
// and the funct3/funct7 values the decoder recognises.
package exec_pipe_unit_pkg;

  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/exec_pipe_unit_alu_core.sv
// Purely combinational integer ALU: op, a, b -> result. Shifts use the low
// log2(DATA_WIDTH) bits of b; compares return a zero-extended 0/1.
module alu_core
  import exec_pipe_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = DATA_WIDTH'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exec_pipe_unit.sv
// Parametrised RV32I OP/OP-IMM execute pipeline with valid/ready backpressure,
// flush, illegal-op flag, destination tag pass-through and a saturating retire counter.
module exec_pipe_unit
  import exec_pipe_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 21,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  uop_valid_in,
  output logic                  uop_ready_out,
  input  logic [6:0]            instruction_type,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic [DATA_WIDTH-1:0] data_src1,
  input  logic [DATA_WIDTH-1:0] data_src2,
  input  logic [TAG_WIDTH-1:0]  rd_in,
  input  logic                  result_ready_in,
  output logic                  uop_valid_out,
  output logic [DATA_WIDTH-1:0] Execution_Result,
  output logic [TAG_WIDTH-1:0]  rd_out,
  output logic                  illegal_op,
  output logic [CNT_WIDTH-1:0]  retire_count
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]    vld_q;
  logic [STAGES-1:0]    adv;
  logic [STAGES-1:0]    ill_q;
  logic [TAG_WIDTH-1:0] tag_q [STAGES];
  logic [DATA_WIDTH-1:0] res_q [1:LAST];

  alu_op_e               op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] alu_res;

  alu_op_e               dec_op;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_ill;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic                  in_xfer;
  logic                  f7_base;
  logic                  f7_alt;

  assign imm_sext = {{(DATA_WIDTH-12){immediate[11]}}, immediate[11:0]};
  assign f7_base  = (funct7 == F7_BASE);
  assign f7_alt   = (funct7 == F7_ALT);

  if (IMM_WIDTH > 12) begin : g_imm_unused
    logic unused_imm_hi;
    assign unused_imm_hi = ^immediate[IMM_WIDTH-1:12];
  end

  always_comb begin
    dec_op  = ALU_ADD;
    dec_b   = data_src2;
    dec_ill = 1'b0;
    unique case (instruction_type)
      OPC_OP: begin
        unique case (funct3)
          F3_ADD:  begin dec_op = f7_alt ? ALU_SUB : ALU_ADD; dec_ill = ~(f7_base | f7_alt); end
          F3_SR:   begin dec_op = f7_alt ? ALU_SRA : ALU_SRL; dec_ill = ~(f7_base | f7_alt); end
          F3_SLL:  begin dec_op = ALU_SLL;  dec_ill = ~f7_base; end
          F3_SLT:  begin dec_op = ALU_SLT;  dec_ill = ~f7_base; end
          F3_SLTU: begin dec_op = ALU_SLTU; dec_ill = ~f7_base; end
          F3_XOR:  begin dec_op = ALU_XOR;  dec_ill = ~f7_base; end
          F3_OR:   begin dec_op = ALU_OR;   dec_ill = ~f7_base; end
          F3_AND:  begin dec_op = ALU_AND;  dec_ill = ~f7_base; end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_b = imm_sext;
        unique case (funct3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLL:  dec_op = ALU_SLL;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_SR:   dec_op = immediate[10] ? ALU_SRA : ALU_SRL;
          F3_OR:   dec_op = ALU_OR;
          F3_AND:  dec_op = ALU_AND;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // A stage advances iff some stage from it to the output is empty, or writeback takes the result.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign adv[g] = result_ready_in | ~(&vld_q[LAST:g]);
  end

  assign uop_ready_out = adv[0];
  assign in_xfer       = uop_valid_in & adv[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[0]   <= 1'b0;
      op_q       <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      tag_q[0]   <= '0;
      ill_q[0]   <= 1'b0;
    end else begin
      if (flush)
        vld_q[0] <= 1'b0;
      else if (adv[0])
        vld_q[0] <= in_xfer;
      if (in_xfer) begin
        op_q     <= dec_op;
        a_q      <= data_src1;
        b_q      <= dec_b;
        tag_q[0] <= rd_in;
        ill_q[0] <= dec_ill;
      end
    end
  end

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    logic [DATA_WIDTH-1:0] d_in;

    if (g == 1) begin : g_alu_in
      assign d_in = ill_q[0] ? '0 : alu_res;
    end else begin : g_dly_in
      assign d_in = res_q[g-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[g] <= 1'b0;
        res_q[g] <= '0;
        tag_q[g] <= '0;
        ill_q[g] <= 1'b0;
      end else begin
        if (flush)
          vld_q[g] <= 1'b0;
        else if (adv[g])
          vld_q[g] <= vld_q[g-1];
        if (adv[g] && vld_q[g-1]) begin
          res_q[g] <= d_in;
          tag_q[g] <= tag_q[g-1];
          ill_q[g] <= ill_q[g-1];
        end
      end
    end
  end

  assign uop_valid_out    = vld_q[LAST];
  assign Execution_Result = res_q[LAST];
  assign rd_out           = tag_q[LAST];
  assign illegal_op       = ill_q[LAST];

  always_ff @(posedge clk) begin
    if (reset)
      retire_count <= '0;
    else if (!flush && vld_q[LAST] && result_ready_in && (retire_count != '1))
      retire_count <= retire_count + CNT_WIDTH'(1);
  end

endmodule
